// File: rtl/ring_pe_port_if.sv
// Link and core-side handshake bundle for ring_pe_port.
// master = the port itself, slave = the NIC/router-core side driving it.
interface ring_pe_port_if #(
  parameter int WIDTH = 64
);
  logic             polarity;
  logic             pe_si;
  logic             pe_ri;
  logic [WIDTH-1:0] pe_di;
  logic             pe_so;
  logic             pe_ro;
  logic [WIDTH-1:0] pe_do;
  logic             inj_valid;
  logic             inj_ready;
  logic [WIDTH-1:0] inj_data;
  logic             ej_valid;
  logic             ej_ready;
  logic [WIDTH-1:0] ej_data;
  logic             vc_err;

  modport master (
    output polarity, pe_ri, pe_so, pe_do, inj_valid, inj_data, ej_ready, vc_err,
    input  pe_si, pe_di, pe_ro, inj_ready, ej_valid, ej_data
  );

  modport slave (
    input  polarity, pe_ri, pe_so, pe_do, inj_valid, inj_data, ej_ready, vc_err,
    output pe_si, pe_di, pe_ro, inj_ready, ej_valid, ej_data
  );
endinterface

// File: rtl/ring_pe_port.sv
// Router-side NIC endpoint: per-VC injection/ejection buffers, each touched by the
// NIC only in its external phase and by the router core only in its internal phase.
module ring_pe_port #(
  parameter int WIDTH  = 64,
  parameter int VC_BIT = 0
) (
  input  logic           clk,
  input  logic           reset,
  ring_pe_port_if.master bus
);

  logic             polarity_reg;
  logic             vc_err_reg;
  logic             int_vc;
  logic             ext_vc;

  logic [1:0]       in_full;
  logic [1:0]       out_full;
  logic [WIDTH-1:0] in_buf  [2];
  logic [WIDTH-1:0] out_buf [2];

  logic             pe_ri_c;
  logic             inj_hit;
  logic             inj_take;
  logic             inj_bad;
  logic             inj_valid_c;
  logic             inj_pop;
  logic             ej_ready_c;
  logic             ej_hit;
  logic             ej_take;
  logic             ej_bad;
  logic             pe_so_c;

  assign int_vc = polarity_reg;
  assign ext_vc = ~polarity_reg;

  // Handshake outputs are gated by reset so they read 0 while reset is held low.
  always_comb begin
    pe_ri_c     = reset & ~in_full[ext_vc];
    inj_hit     = bus.pe_si & pe_ri_c;
    inj_take    = inj_hit & (bus.pe_di[VC_BIT] == ext_vc);
    inj_bad     = inj_hit & (bus.pe_di[VC_BIT] != ext_vc);
    inj_valid_c = reset & in_full[int_vc];
    inj_pop     = inj_valid_c & bus.inj_ready;
    ej_ready_c  = reset & ~out_full[int_vc];
    ej_hit      = bus.ej_valid & ej_ready_c;
    ej_take     = ej_hit & (bus.ej_data[VC_BIT] == int_vc);
    ej_bad      = ej_hit & (bus.ej_data[VC_BIT] != int_vc);
    pe_so_c     = reset & out_full[ext_vc] & bus.pe_ro;
  end

  assign bus.polarity  = polarity_reg;
  assign bus.vc_err    = vc_err_reg;
  assign bus.pe_ri     = pe_ri_c;
  assign bus.inj_valid = inj_valid_c;
  assign bus.inj_data  = inj_valid_c ? in_buf[int_vc] : '0;
  assign bus.ej_ready  = ej_ready_c;
  assign bus.pe_so     = pe_so_c;
  assign bus.pe_do     = out_full[ext_vc] ? out_buf[ext_vc] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_reg <= 1'b0;
      vc_err_reg   <= 1'b0;
    end else begin
      polarity_reg <= ~polarity_reg;
      if (inj_bad || ej_bad)
        vc_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      localparam logic VC = 1'(gi);

      logic [WIDTH-1:0] in_buf_reg;
      logic             in_full_reg;
      logic [WIDTH-1:0] out_buf_reg;
      logic             out_full_reg;

      // Fill happens only when this VC is external, drain only when internal
      // (or the reverse for ejection), so set and clear never collide.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          in_buf_reg   <= '0;
          in_full_reg  <= 1'b0;
          out_buf_reg  <= '0;
          out_full_reg <= 1'b0;
        end else begin
          if (inj_take && (ext_vc == VC)) begin
            in_buf_reg  <= bus.pe_di;
            in_full_reg <= 1'b1;
          end else if (inj_pop && (int_vc == VC)) begin
            in_full_reg <= 1'b0;
          end

          if (ej_take && (int_vc == VC)) begin
            out_buf_reg  <= bus.ej_data;
            out_full_reg <= 1'b1;
          end else if (pe_so_c && (ext_vc == VC)) begin
            out_full_reg <= 1'b0;
          end
        end
      end

      assign in_buf[gi]   = in_buf_reg;
      assign in_full[gi]  = in_full_reg;
      assign out_buf[gi]  = out_buf_reg;
      assign out_full[gi] = out_full_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ring_pe_port.sv
// Directed bench for ring_pe_port: stimulus pushes expected packets, a forked
// monitor pops and compares them whenever a handshake fires.
module tb_ring_pe_port;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ring_pe_port_if #(.WIDTH(W)) bus();

  ring_pe_port #(.WIDTH(W), .VC_BIT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t inj_q[$];
  exp_t pe_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic p_model;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset)
    if (!reset) p_model <= 1'b0;
    else        p_model <= ~p_model;

  localparam logic [W-1:0] D_A  = 64'h1111_2222_3333_4444;
  localparam logic [W-1:0] D_B  = 64'h5555_6666_7777_8889;
  localparam logic [W-1:0] D1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] D1E  = 64'h0123_4567_89AB_CDEE;
  localparam logic [W-1:0] D2   = 64'hFEDC_BA98_7654_3210;
  localparam logic [W-1:0] D3   = 64'h0F0F_0F0F_0F0F_0F00;
  localparam logic [W-1:0] DAA  = 64'h0000_0000_0000_00AA;
  localparam logic [W-1:0] DBAD = 64'h5555_0000_0000_0001;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("polarity", 64'(bus.polarity), 64'(p_model));
        if (bus.inj_valid && bus.inj_ready) begin
          if (inj_q.size() == 0) begin
            total++; bad++;
            $display("FAIL inj_unexpected: got %h want none (cycle %0d)", bus.inj_data, cyc);
          end else begin
            e = inj_q.pop_front();
            chk("inj_data", bus.inj_data, e.data);
            if (e.due != 0) chk("inj_latency", 64'(cyc), 64'(e.due));
          end
        end
        if (bus.pe_so) begin
          if (pe_q.size() == 0) begin
            total++; bad++;
            $display("FAIL pe_unexpected: got %h want none (cycle %0d)", bus.pe_do, cyc);
          end else begin
            e = pe_q.pop_front();
            chk("pe_do", bus.pe_do, e.data);
            if (e.due != 0) chk("pe_latency", 64'(cyc), 64'(e.due));
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic want);
    step();
    while (p_model != want) step();
  endtask

  initial begin
    bus.pe_si = 1'b0; bus.pe_di = '0; bus.pe_ro = 1'b0;
    bus.inj_ready = 1'b0; bus.ej_valid = 1'b0; bus.ej_data = '0;
    fork
      monitor();
    join_none

    // Bring up, then load in_full[0] and out_full[1] before a mid-traffic reset.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wait_phase(1'b1);
    bus.pe_si = 1'b1; bus.pe_di = D_A;
    bus.ej_valid = 1'b1; bus.ej_data = D_B;
    step();
    bus.pe_si = 1'b0; bus.ej_valid = 1'b0;
    #1;
    chk("setup_inj_valid", 64'(bus.inj_valid), 64'd1);
    chk("setup_inj_data", bus.inj_data, D_A);
    reset = 1'b0;
    bus.pe_ro = 1'b1; bus.pe_si = 1'b1; bus.ej_valid = 1'b1;
    #1;
    chk("rst_pe_ri", 64'(bus.pe_ri), 64'd0);
    chk("rst_pe_so", 64'(bus.pe_so), 64'd0);
    chk("rst_inj_valid", 64'(bus.inj_valid), 64'd0);
    chk("rst_ej_ready", 64'(bus.ej_ready), 64'd0);
    chk("rst_inj_data", bus.inj_data, 64'd0);
    chk("rst_pe_do", bus.pe_do, 64'd0);
    step(); step();
    bus.pe_si = 1'b0; bus.ej_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_polarity", 64'(bus.polarity), 64'd0);
    chk("rel_pe_ri", 64'(bus.pe_ri), 64'd1);
    chk("rel_inj_valid", 64'(bus.inj_valid), 64'd0);
    chk("rel_pe_so", 64'(bus.pe_so), 64'd0);
    chk("rel_ej_ready", 64'(bus.ej_ready), 64'd1);
    chk("rel_vc_err", 64'(bus.vc_err), 64'd0);

    // Single VC0 injection, forwarded one cycle later.
    wait_phase(1'b1);
    bus.pe_ro = 1'b0; bus.inj_ready = 1'b1;
    bus.pe_si = 1'b1; bus.pe_di = D1E;
    inj_q.push_back('{D1E, cyc + 1});
    #1 chk("t2_pe_ri", 64'(bus.pe_ri), 64'd1);
    step();
    bus.pe_si = 1'b0;
    #1;
    chk("t2_inj_valid", 64'(bus.inj_valid), 64'd1);
    chk("t2_inj_data", bus.inj_data, D1E);
    step();
    #1 chk("t2_inj_valid_p1", 64'(bus.inj_valid), 64'd0);
    step();
    #1;
    chk("t2_inj_valid_drained", 64'(bus.inj_valid), 64'd0);
    chk("t2_vc_err", 64'(bus.vc_err), 64'd0);

    // Held injection: visible only on p=0, second packet refused.
    wait_phase(1'b1);
    bus.inj_ready = 1'b0;
    bus.pe_si = 1'b1; bus.pe_di = D2;
    inj_q.push_back('{D2, 0});
    step();
    for (int k = 0; k < 6; k++) begin
      if (p_model) begin bus.pe_si = 1'b1; bus.pe_di = D3; end
      else bus.pe_si = 1'b0;
      #1;
      if (p_model) begin
        chk("t3_pe_ri_blocked", 64'(bus.pe_ri), 64'd0);
        chk("t3_inj_valid_p1", 64'(bus.inj_valid), 64'd0);
      end else begin
        chk("t3_inj_valid_p0", 64'(bus.inj_valid), 64'd1);
        chk("t3_inj_data", bus.inj_data, D2);
      end
      step();
    end
    bus.pe_si = 1'b0;
    bus.inj_ready = 1'b1;
    #1 chk("t3_release_valid", 64'(bus.inj_valid), 64'd1);
    repeat (4) step();

    // Ejection held off by pe_ro=0, then delivered for exactly one cycle.
    wait_phase(1'b0);
    bus.pe_ro = 1'b0;
    bus.ej_valid = 1'b1; bus.ej_data = DAA;
    pe_q.push_back('{DAA, 0});
    #1 chk("t4_ej_ready", 64'(bus.ej_ready), 64'd1);
    step();
    bus.ej_valid = 1'b0;
    #1 chk("t4_pe_so_wait1", 64'(bus.pe_so), 64'd0);
    step();
    #1 chk("t4_pe_so_wait2", 64'(bus.pe_so), 64'd0);
    step();
    bus.pe_ro = 1'b1;
    #1;
    chk("t4_pe_so", 64'(bus.pe_so), 64'd1);
    chk("t4_pe_do", bus.pe_do, DAA);
    step();
    #1 chk("t4_pe_so_after1", 64'(bus.pe_so), 64'd0);
    step();
    #1;
    chk("t4_pe_so_after2", 64'(bus.pe_so), 64'd0);
    chk("t4_pe_do_after", bus.pe_do, 64'd0);

    // VC mismatch on injection: dropped, vc_err sticky.
    wait_phase(1'b1);
    bus.pe_si = 1'b1; bus.pe_di = DBAD;
    #1 chk("t5_vc_err_before", 64'(bus.vc_err), 64'd0);
    step();
    bus.pe_si = 1'b0;
    #1;
    chk("t5_vc_err", 64'(bus.vc_err), 64'd1);
    chk("t5_dropped", 64'(bus.inj_valid), 64'd0);
    step(); step();
    #1;
    chk("t5_vc_err_sticky", 64'(bus.vc_err), 64'd1);
    chk("t5_still_dropped", 64'(bus.inj_valid), 64'd0);

    // Back-to-back: VC0 injection and VC1 ejection every p=1 cycle.
    bus.inj_ready = 1'b1; bus.pe_ro = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] din;
      logic [W-1:0] dej;
      wait_phase(1'b1);
      din = {32'hA000_0000 + 32'(k), 32'(k * 4)};
      dej = {32'hB000_0000 + 32'(k), 32'(k * 4 + 1)};
      bus.pe_si = 1'b1; bus.pe_di = din;
      bus.ej_valid = 1'b1; bus.ej_data = dej;
      inj_q.push_back('{din, cyc + 1});
      pe_q.push_back('{dej, cyc + 1});
      #1;
      chk("t6_pe_ri", 64'(bus.pe_ri), 64'd1);
      chk("t6_ej_ready", 64'(bus.ej_ready), 64'd1);
      step();
      bus.pe_si = 1'b0; bus.ej_valid = 1'b0;
    end
    repeat (4) step();

    chk("inj_q_drained", 64'(inj_q.size()), 64'd0);
    chk("pe_q_drained", 64'(pe_q.size()), 64'd0);
    chk("final_vc_err", 64'(bus.vc_err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
